// File: rtl/sram_req_arbiter_pkg.sv
// sram_req_arbiter_pkg: shared arbitration-mode, transfer-size and FSM definitions.
package sram_req_arbiter_pkg;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;
endpackage

// File: rtl/sram_req_arbiter_id.sv
// id_fifo: in-order port-ID queue for outstanding transactions; DEPTH is a power of 2.
module id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: N-to-1 SRAM-like request arbiter with in-order response routing.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MAX_OUTST = 4,
    parameter int ARB_MODE  = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          s_req,
    input  logic [NUM_PORTS-1:0]          s_wr,
    input  logic [2*NUM_PORTS-1:0]        s_size,
    input  logic [(DATA_W/8)*NUM_PORTS-1:0] s_wstrb,
    input  logic [ADDR_W*NUM_PORTS-1:0]   s_addr,
    input  logic [DATA_W*NUM_PORTS-1:0]   s_wdata,
    output logic [NUM_PORTS-1:0]          s_addr_ok,
    output logic [NUM_PORTS-1:0]          s_data_ok,
    output logic [DATA_W*NUM_PORTS-1:0]   s_rdata,
    output logic                          m_req,
    output logic                          m_wr,
    output logic [1:0]                    m_size,
    output logic [DATA_W/8-1:0]           m_wstrb,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_wdata,
    input  logic                          m_addr_ok,
    input  logic                          m_data_ok,
    input  logic [DATA_W-1:0]             m_rdata,
    output logic [$clog2(MAX_OUTST):0]    outst_cnt,
    output logic                          err_unexp
);
    localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int SW = DATA_W / 8;
    arb_state_e state;
    logic [IW-1:0] lock_idx, rr_ptr, fix_gnt, rr_gnt, gnt, idx, head;
    logic [NUM_PORTS-1:0] elig;
    logic gnt_vld, hs, pop, full, empty;
    always_comb begin
        elig    = full ? '0 : s_req;
        fix_gnt = '0;
        rr_gnt  = '0;
        idx     = '0;
        // Scan downward so the nearest eligible port is the last one written.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (elig[IW'(k)]) fix_gnt = IW'(k);
            idx = IW'((int'(rr_ptr) + k) % NUM_PORTS);
            if (elig[idx]) rr_gnt = idx;
        end
    end
    assign gnt     = (state == ST_LOCKED) ? lock_idx : (ARB_MODE == ARB_RR ? rr_gnt : fix_gnt);
    assign gnt_vld = ~reset & ((state == ST_LOCKED) | (|elig));
    assign hs      = gnt_vld & m_addr_ok;
    assign pop     = ~reset & m_data_ok & ~empty;
    assign m_req   = gnt_vld;
    assign m_wr    = gnt_vld & s_wr[gnt];
    assign m_size  = gnt_vld ? s_size[2*int'(gnt) +: 2] : '0;
    assign m_wstrb = gnt_vld ? s_wstrb[SW*int'(gnt) +: SW] : '0;
    assign m_addr  = gnt_vld ? s_addr[ADDR_W*int'(gnt) +: ADDR_W] : '0;
    assign m_wdata = gnt_vld ? s_wdata[DATA_W*int'(gnt) +: DATA_W] : '0;
    always_comb begin
        s_addr_ok = '0;
        s_data_ok = '0;
        s_rdata   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_addr_ok[i] = hs && gnt == IW'(i);
            s_data_ok[i] = pop && head == IW'(i);
            s_rdata[i*DATA_W +: DATA_W] = s_data_ok[i] ? m_rdata : '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lock_idx  <= '0;
            rr_ptr    <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (m_data_ok && empty) err_unexp <= 1'b1;
            if (hs && ARB_MODE == ARB_RR) rr_ptr <= (gnt == IW'(NUM_PORTS - 1)) ? '0 : gnt + IW'(1);
            // A request left waiting must not be re-arbitrated away before it is accepted.
            if (state == ST_IDLE && m_req && !m_addr_ok) begin
                state    <= ST_LOCKED;
                lock_idx <= gnt;
            end else if (state == ST_LOCKED && m_addr_ok) begin
                state <= ST_IDLE;
            end
        end
    end
    id_fifo #(.WIDTH(IW), .DEPTH(MAX_OUTST)) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hs),
        .pop   (pop),
        .din   (gnt),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (outst_cnt)
    );
endmodule
